hud_number_display: RTL and testbench

- Parametrised HUD numeric overlay. Accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine.
- Renders the value as NUM_DIGITS glyph sprites in a fixed row, with optional leading-zero blanking and overflow saturation.
- Sits on the VGA pixel path and produces a 24-bit RGB pixel for the overlay mixer.
- Reads glyph bitmaps from an external 1-cycle-latency glyph ROM.

---
 rtl/hud_number_display.sv | 262 ++++++++++++++++++++++++++
 tb/tb_hud_number_display.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hud_number_display.sv
`default_nettype none
// ============================================================================
// Module      : hud_number_display
// Description : HUD numeric overlay. A binary value arrives over valid/ready,
//               is converted to BCD by a sequential double-dabble engine and
//               is drawn as NUM_DIGITS glyph sprites in a fixed screen row.
//               Glyph bitmaps come from an external glyph ROM that has one
//               cycle of read latency.
// Ports       : clk         - pixel clock, the only clock
//               reset_n     - asynchronous active-low reset
//               val_valid   - a new value is offered
//               val_data    - binary value to display (VAL_W bits)
//               val_ready   - block can accept a value (idle)
//               hcount      - current pixel x (11 bits)
//               vcount      - current pixel y (10 bits)
//               glyph_addr  - glyph ROM address
//                             (digit*DIGIT_W*DIGIT_H + row*DIGIT_W + col)
//               glyph_bit   - glyph ROM data, one cycle after glyph_addr
//               pixel       - overlay pixel, COLOR when lit, else 0
//               overflow    - last accepted value exceeded 10^NUM_DIGITS-1
// Revision    : 1.0 - initial release
// ============================================================================
module hud_number_display #(
    parameter int          NUM_DIGITS = 4,
    parameter int          VAL_W      = 14,
    parameter int          X0         = 0,
    parameter int          Y0         = 1,
    parameter int          DIGIT_W    = 24,
    parameter int          DIGIT_H    = 32,
    parameter int          SPACING    = 27,
    parameter logic [23:0] COLOR      = 24'hFF0000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             val_valid,
    input  logic [VAL_W-1:0] val_data,
    output logic             val_ready,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    output logic [13:0]      glyph_addr,
    input  logic             glyph_bit,
    output logic [23:0]      pixel,
    output logic             overflow
);

    // Largest value representable in NUM_DIGITS decimal digits.
    function automatic logic [63:0] f_max_value(input int digits);
        logic [63:0] v_p;
        v_p = 64'd1;
        for (int k = 0; k < digits; k++) begin
            v_p = v_p * 64'd10;
        end
        return v_p - 64'd1;
    endfunction

    localparam int          c_bcd_w = 4 * NUM_DIGITS;
    localparam int          c_cnt_w = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int          c_col_w = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;
    localparam int          c_row_w = (DIGIT_H > 1) ? $clog2(DIGIT_H) : 1;
    localparam logic [63:0] c_max   = f_max_value(NUM_DIGITS);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_shift  = 2'd1;
    localparam logic [1:0]  c_st_commit = 2'd2;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_ready;
    logic               w_accept;
    logic               w_shift_en;
    logic               w_commit_en;

    logic [VAL_W-1:0]   r_bin;
    logic [c_bcd_w-1:0] r_bcd;
    logic [c_bcd_w-1:0] w_bcd_adj;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ovf_pend;
    logic [c_bcd_w-1:0] r_digits;
    logic               r_overflow;
    logic               w_val_over;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_shift_en  = 1'b0;
        w_commit_en = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_ready = 1'b1;
                if (val_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_shift;
                end
            end
            c_st_shift: begin
                w_shift_en = 1'b1;
                if (r_cnt == c_cnt_w'(VAL_W - 1)) begin
                    w_state_nxt = c_st_commit;
                end
            end
            c_st_commit: begin
                w_commit_en = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign val_ready  = w_ready;
    assign w_val_over = (64'(val_data) > c_max);

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
            assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                         (r_bcd[4*g +: 4] + 4'd3) :
                                          r_bcd[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_digits   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                // Saturate before converting so the BCD result always fits.
                r_bin      <= w_val_over ? c_max[VAL_W-1:0] : val_data;
                r_ovf_pend <= w_val_over;
                r_bcd      <= '0;
                r_cnt      <= '0;
            end
            if (w_shift_en) begin
                {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                r_cnt          <= r_cnt + 1'b1;
            end
            // The displayed digits only ever change here, in one cycle,
            // so a frame never shows a half-converted number.
            if (w_commit_en) begin
                r_digits   <= r_bcd;
                r_overflow <= r_ovf_pend;
            end
        end
    end

    assign overflow = r_overflow;

    // ------------------------------------------------------------------
    // Leading-zero blanking: digit i is blank if digits 0..i are all zero;
    // the least significant digit is always drawn.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_zero_run;

    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero_run = w_zero_run && (r_digits[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            w_blank[i] = BLANK_LZ && (i != NUM_DIGITS - 1) && w_zero_run;
        end
    end

    // ------------------------------------------------------------------
    // Hit test. Offsets are computed with unsigned wrap-around, so a
    // position left of / above a box becomes huge and simply misses.
    // ------------------------------------------------------------------
    logic [31:0]           w_hpos;
    logic [31:0]           w_vpos;
    logic [31:0]           w_dy;
    logic                  w_vin;
    logic [31:0]           w_dx [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_hit;

    assign w_hpos = 32'(hcount);
    assign w_vpos = 32'(vcount);
    assign w_dy   = w_vpos - 32'(Y0);
    assign w_vin  = (w_dy < 32'(DIGIT_H));

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hit
            localparam logic [31:0] c_left = 32'(X0 + g * SPACING);
            assign w_dx[g]  = w_hpos - c_left;
            assign w_hit[g] = w_vin && (w_dx[g] < 32'(DIGIT_W));
        end
    endgenerate

    // Lowest index wins when boxes overlap: scan high to low, last hit sticks.
    logic               w_found;
    logic               w_sel_blank;
    logic [3:0]         w_sel_digit;
    logic [c_col_w-1:0] w_sel_col;
    logic [c_row_w-1:0] w_row;
    logic [13:0]        w_addr;
    logic               w_lit_cand;

    always_comb begin
        w_found     = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_digit = 4'd0;
        w_sel_col   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_found     = 1'b1;
                w_sel_blank = w_blank[i];
                w_sel_digit = r_digits[4*(NUM_DIGITS-1-i) +: 4];
                w_sel_col   = w_dx[i][c_col_w-1:0];
            end
        end
    end

    assign w_row      = w_dy[c_row_w-1:0];
    assign w_addr     = 14'(w_sel_digit) * 14'(DIGIT_W * DIGIT_H)
                      + 14'(w_row) * 14'(DIGIT_W) + 14'(w_sel_col);
    assign w_lit_cand = w_found && !w_sel_blank;

    // ------------------------------------------------------------------
    // Render pipeline: address register, ROM read, pixel register.
    // ------------------------------------------------------------------
    logic [13:0] r_glyph_addr;
    logic        r_lit;
    logic        r_lit_d1;
    logic [23:0] r_pixel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_glyph_addr <= '0;
            r_lit        <= 1'b0;
            r_lit_d1     <= 1'b0;
            r_pixel      <= '0;
        end else begin
            r_glyph_addr <= w_lit_cand ? w_addr : 14'd0;
            r_lit        <= w_lit_cand;
            r_lit_d1     <= r_lit;
            r_pixel      <= (r_lit_d1 && glyph_bit) ? COLOR : 24'd0;
        end
    end

    assign glyph_addr = r_glyph_addr;
    assign pixel      = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_hud_number_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_hud_number_display
// Description : Scoreboard bench for hud_number_display. Two instances share
//               all inputs: one with leading-zero blanking, one without.
//               Each has its own registered glyph ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hud_number_display;

    localparam int          N     = 4;
    localparam int          VW    = 14;
    localparam int          X0    = 0;
    localparam int          Y0    = 1;
    localparam int          DW    = 24;
    localparam int          DH    = 32;
    localparam int          SP    = 27;
    localparam logic [23:0] COLOR = 24'hFF0000;
    localparam int unsigned MAXV  = 9999;

    logic          clk;
    logic          reset_n;
    logic          val_valid;
    logic [VW-1:0] val_data;
    logic          val_ready, val_ready_nb;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic [13:0]   glyph_addr, glyph_addr_nb;
    logic          glyph_bit, glyph_bit_nb;
    logic [23:0]   pixel, pixel_nb;
    logic          overflow, overflow_nb;

    hud_number_display u_dut (
        .clk(clk), .reset_n(reset_n), .val_valid(val_valid), .val_data(val_data),
        .val_ready(val_ready), .hcount(hcount), .vcount(vcount),
        .glyph_addr(glyph_addr), .glyph_bit(glyph_bit), .pixel(pixel),
        .overflow(overflow)
    );

    hud_number_display #(.BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .reset_n(reset_n), .val_valid(val_valid), .val_data(val_data),
        .val_ready(val_ready_nb), .hcount(hcount), .vcount(vcount),
        .glyph_addr(glyph_addr_nb), .glyph_bit(glyph_bit_nb), .pixel(pixel_nb),
        .overflow(overflow_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Glyph ROM: arbitrary bit pattern so wrong addresses change the pixel.
    function automatic logic rom_bit(input logic [13:0] a);
        return a[0] ^ a[3] ^ a[6] ^ a[10];
    endfunction

    always @(posedge clk) begin
        glyph_bit    <= rom_bit(glyph_addr);
        glyph_bit_nb <= rom_bit(glyph_addr_nb);
    end

    // ------------------------------------------------------------------
    // Reference model: decimal arithmetic and box geometry.
    // ------------------------------------------------------------------
    function automatic int unsigned pow10(input int e);
        int unsigned p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic void model(input int unsigned v, input int hc, input int vc,
                                  input bit blz, output logic [13:0] a,
                                  output logic [23:0] p);
        int hitd;
        hitd = -1;
        a = '0;
        p = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hc >= X0 + i*SP && hc < X0 + i*SP + DW && vc >= Y0 && vc < Y0 + DH)
                hitd = i;
        end
        if (hitd >= 0) begin
            int unsigned d;
            bit          blank;
            d     = (v / pow10(N - 1 - hitd)) % 10;
            blank = blz && (hitd < N - 1) && (v < pow10(N - 1 - hitd));
            if (!blank) begin
                a = 14'(d*DW*DH + (vc - Y0)*DW + (hc - X0 - hitd*SP));
                p = rom_bit(a) ? COLOR : 24'd0;
            end
        end
    endfunction

    typedef struct {
        int unsigned val;
        bit          ovf;
        bit          is_reset;
        int unsigned acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_push = 0;
    int   n_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_point(input int unsigned v, input int hc, input int vc);
        logic [13:0] ea, eanb;
        logic [23:0] ep, epnb;
        model(v, hc, vc, 1'b1, ea, ep);
        model(v, hc, vc, 1'b0, eanb, epnb);
        hcount = 11'(hc);
        vcount = 10'(vc);
        @(negedge clk);
        check("glyph_addr",      32'(glyph_addr),    32'(ea));
        check("glyph_addr_nolz", 32'(glyph_addr_nb), 32'(eanb));
        repeat (2) @(negedge clk);
        check("pixel",      32'(pixel),    32'(ep));
        check("pixel_nolz", 32'(pixel_nb), 32'(epnb));
    endtask

    task automatic check_display(input int unsigned v);
        for (int i = 0; i < N; i++) begin
            check_point(v, X0 + i*SP + int'($urandom_range(DW - 1, 0)),
                        Y0 + int'($urandom_range(DH - 1, 0)));
            if (i < N - 1)
                check_point(v, X0 + i*SP + DW + int'($urandom_range(SP - DW - 1, 0)),
                            Y0 + int'($urandom_range(DH - 1, 0)));
        end
        check_point(v, X0 + (N-1)*SP + 5, Y0 + 4);
        check_point(v, X0 + (N-1)*SP + int'($urandom_range(DW - 1, 0)), Y0 + DH);
        check_point(v, X0 + N*SP, Y0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops an expectation whenever val_ready rises.
    // ------------------------------------------------------------------
    initial begin
        int unsigned shown;
        logic        prev_rdy;
        bit          early_chg;
        exp_t        e;
        hcount = '0;
        vcount = '0;
        repeat (2) @(negedge clk);
        check("reset_ready",    32'(val_ready),  32'd1);
        check("reset_overflow", 32'(overflow),   32'd0);
        check("reset_addr",     32'(glyph_addr), 32'd0);
        check("reset_pixel",    32'(pixel),      32'd0);
        while (!reset_n) @(negedge clk);
        check_display(0);
        shown     = 0;
        early_chg = 1'b0;
        hcount    = 11'(X0 + (N-1)*SP);
        vcount    = 10'(Y0);
        prev_rdy  = val_ready;
        n_done    = 1;
        forever begin
            @(negedge clk);
            if (val_ready === 1'b0 && reset_n === 1'b1) begin
                if (glyph_addr !== 14'((shown % 10) * DW * DH) ||
                    glyph_addr_nb !== 14'((shown % 10) * DW * DH))
                    early_chg = 1'b1;
            end
            if (val_ready === 1'b1 && prev_rdy === 1'b0) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: got ready rise, expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    if (!e.is_reset) begin
                        check("ready_latency", cyc - e.acc, 32'(VW + 2));
                        check("display_held_while_busy", 32'(early_chg), 32'd0);
                    end else begin
                        repeat (VW + 6) @(negedge clk);
                    end
                    check("ready_nolz", 32'(val_ready_nb), 32'd1);
                    check("overflow",      32'(overflow),    32'(e.ovf));
                    check("overflow_nolz", 32'(overflow_nb), 32'(e.ovf));
                    check_display(e.val);
                    shown = e.val;
                end
                early_chg = 1'b0;
                hcount    = 11'(X0 + (N-1)*SP);
                vcount    = 10'(Y0);
                n_done++;
            end
            prev_rdy = val_ready;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic offer(input int unsigned v, output int unsigned acc);
        int k = 0;
        val_data  = VW'(v);
        val_valid = 1'b1;
        while (val_ready !== 1'b1) begin
            @(negedge clk);
            k++;
            if (k > 100) begin
                $display("FAIL accept_timeout: ready stuck low, expected high");
                $fatal(1, "accept timeout");
            end
        end
        acc = cyc;
        @(negedge clk);
        // Offers while busy must be ignored.
        val_data = VW'($urandom);
        repeat (3) @(negedge clk);
        val_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (n_done < n_push) begin
            @(negedge clk);
            k++;
            if (k > 3000) begin
                $display("FAIL monitor_timeout: done %0d, expected %0d", n_done, n_push);
                $fatal(1, "monitor timeout");
            end
        end
    endtask

    task automatic send(input int unsigned v);
        exp_t        e;
        int unsigned acc;
        offer(v, acc);
        e.val      = sat(v);
        e.ovf      = (v > MAXV);
        e.is_reset = 1'b0;
        e.acc      = acc;
        sb.push_back(e);
        n_push++;
        wait_done();
    endtask

    initial begin
        int unsigned dir[10] = '{1234, 7, 12000, 5, 0, 9999, 10000, 16383, 100, 90};
        exp_t        e;
        int unsigned acc;
        reset_n   = 1'b0;
        val_valid = 1'b0;
        val_data  = '0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        n_push  = 1;
        wait_done();
        foreach (dir[i]) send(dir[i]);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1, 0) == 0) send($urandom_range(99, 0));
            else                           send($urandom_range(16383, 0));
        end
        // Reset in the middle of a conversion: display must fall to 0.
        send(12000);
        offer(9999, acc);
        @(negedge clk);
        e.val      = 0;
        e.ovf      = 1'b0;
        e.is_reset = 1'b1;
        e.acc      = 0;
        sb.push_back(e);
        n_push++;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_done();
        send(42);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
